// File: rtl/pwm_signal_generator_pkg.sv
// -----------------------------------------------------------------------------
// pwm_signal_generator_pkg
// Shared definitions for the PWM generator and its capture/processor
// counterparts: generator state encodings and the default time-field width.
// No ports (package).
// -----------------------------------------------------------------------------
package pwm_signal_generator_pkg;

    // Default width of high_time / low_time fields and phase counters.
    localparam int CNT_WIDTH_DEF = 32;

    // Generator FSM states. The period-start step is not a separate state:
    // it is folded into the transition that enters HIGH or LOW.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } gen_state_e;

endpackage

// File: rtl/pwm_signal_generator_if.sv
// -----------------------------------------------------------------------------
// pwm_signal_generator_if
// Configuration handshake bundle for the PWM generator.
//   cfg_valid      : config offer (master -> slave)
//   cfg_ready      : slave can accept a config (slave -> master)
//   cfg_high_time  : high phase length in clk cycles
//   cfg_low_time   : low phase length in clk cycles
// Modports: master (config source), slave (generator).
// -----------------------------------------------------------------------------
import pwm_signal_generator_pkg::*;

interface pwm_signal_generator_if #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_WIDTH-1:0] cfg_high_time;
    logic [CNT_WIDTH-1:0] cfg_low_time;

    modport master (
        output cfg_valid,
        output cfg_high_time,
        output cfg_low_time,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_high_time,
        input  cfg_low_time,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_signal_generator_gen_cfg_buffer.sv
// -----------------------------------------------------------------------------
// gen_cfg_buffer
// Single-entry pending buffer for generator configurations.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg           : config handshake (slave side); cfg_ready = buffer empty
//   apply_req     : generator consumes the pending entry this cycle
//   pending_hi/lo : buffered config
//   pending_full  : buffer holds a config
//   cfg_applied   : 1-cycle pulse after the pending entry was consumed
//   cfg_error     : 1-cycle pulse after an all-zero config was offered
// -----------------------------------------------------------------------------
import pwm_signal_generator_pkg::*;

module gen_cfg_buffer #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pwm_signal_generator_if.slave   cfg,
    input  logic                    apply_req,
    output logic [CNT_WIDTH-1:0]    pending_hi,
    output logic [CNT_WIDTH-1:0]    pending_lo,
    output logic                    pending_full,
    output logic                    cfg_applied,
    output logic                    cfg_error
);

    logic transfer;
    logic cfg_zero;
    logic apply;

    assign cfg.cfg_ready = !pending_full;
    assign transfer      = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_zero      = (cfg.cfg_high_time == '0) && (cfg.cfg_low_time == '0);
    // Transfer and apply are mutually exclusive: one needs the buffer empty,
    // the other needs it full.
    assign apply         = apply_req && pending_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            cfg_applied  <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            cfg_applied <= apply;
            cfg_error   <= transfer && cfg_zero;
            if (apply) begin
                pending_full <= 1'b0;
            end else if (transfer && !cfg_zero) begin
                pending_full <= 1'b1;
            end
        end
    end

    // Config data is qualified by pending_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (transfer && !cfg_zero) begin
            pending_hi <= cfg.cfg_high_time;
            pending_lo <= cfg.cfg_low_time;
        end
    end

endmodule

// File: rtl/pwm_signal_generator.sv
// -----------------------------------------------------------------------------
// pwm_signal_generator
// Programmable PWM source: signal_out is high for high_time clocks, then low
// for low_time clocks. New configs are double-buffered and only take effect at
// a period boundary (or immediately while idle), so the output never glitches.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run request; low returns to idle
//   cfg          : config handshake (valid/ready/high_time/low_time)
//   signal_out   : generated waveform (registered)
//   period_start : 1-cycle pulse in the first cycle of every period
//   cfg_applied  : 1-cycle pulse when a pending config becomes active
//   cfg_error    : 1-cycle pulse when an all-zero config is rejected
// -----------------------------------------------------------------------------
import pwm_signal_generator_pkg::*;

module pwm_signal_generator #(
    parameter int                   CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_HI = '0,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_LO = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    pwm_signal_generator_if.slave   cfg,
    output logic                    signal_out,
    output logic                    period_start,
    output logic                    cfg_applied,
    output logic                    cfg_error
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    gen_state_e           state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [CNT_WIDTH-1:0] active_hi, active_lo;
    logic [CNT_WIDTH-1:0] pending_hi, pending_lo;
    logic                 pending_full;
    logic                 apply_req;
    logic                 hi_last, lo_last, boundary;
    logic [CNT_WIDTH-1:0] eff_hi, eff_lo;
    logic                 eff_valid;
    logic                 start_period;
    logic                 signal_out_d, period_start_d;

    gen_cfg_buffer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cfg_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg),
        .apply_req    (apply_req),
        .pending_hi   (pending_hi),
        .pending_lo   (pending_lo),
        .pending_full (pending_full),
        .cfg_applied  (cfg_applied),
        .cfg_error    (cfg_error)
    );

    // Last-cycle detection; subtraction stays in CNT_WIDTH so a maximal
    // phase length compares cleanly without wrap.
    assign hi_last  = (cnt == active_hi - ONE);
    assign lo_last  = (cnt == active_lo - ONE);
    assign boundary = ((state == ST_HIGH) && hi_last && (active_lo == '0)) ||
                      ((state == ST_LOW)  && lo_last);

    assign apply_req = pending_full && ((state == ST_IDLE) || boundary);

    // The period that starts on an apply cycle already uses the new config.
    assign eff_hi    = apply_req ? pending_hi : active_hi;
    assign eff_lo    = apply_req ? pending_lo : active_lo;
    assign eff_valid = (eff_hi != '0) || (eff_lo != '0);

    // Next-state logic
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        start_period = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && eff_valid) begin
                    start_period = 1'b1;
                    state_next   = (eff_hi != '0) ? ST_HIGH : ST_LOW;
                    cnt_next     = '0;
                end
            end
            ST_HIGH: begin
                if (hi_last) begin
                    cnt_next = '0;
                    if (active_lo != '0) begin
                        state_next = ST_LOW;
                    end else begin
                        start_period = 1'b1;
                        state_next   = (eff_hi != '0) ? ST_HIGH : ST_LOW;
                    end
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            ST_LOW: begin
                if (lo_last) begin
                    start_period = 1'b1;
                    state_next   = (eff_hi != '0) ? ST_HIGH : ST_LOW;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if ((state != ST_IDLE) && !enable) begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            start_period = 1'b0;
        end
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        signal_out_d   = (state_next == ST_HIGH);
        period_start_d = start_period;
    end

    // State, counter, active config and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            active_hi    <= DEFAULT_HI;
            active_lo    <= DEFAULT_LO;
            signal_out   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            signal_out   <= signal_out_d;
            period_start <= period_start_d;
            if (apply_req) begin
                active_hi <= pending_hi;
                active_lo <= pending_lo;
            end
        end
    end

endmodule

// File: tb/tb_pwm_signal_generator.sv
module tb_pwm_signal_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic signal_out, period_start, cfg_applied, cfg_error;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_signal_generator_if #(.CNT_WIDTH(32)) cfg_if();

    pwm_signal_generator #(
        .CNT_WIDTH  (32),
        .DEFAULT_HI (32'd0),
        .DEFAULT_LO (32'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg          (cfg_if),
        .signal_out   (signal_out),
        .period_start (period_start),
        .cfg_applied  (cfg_applied),
        .cfg_error    (cfg_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable               = 1'b0;
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_high_time = '0;
        cfg_if.cfg_low_time  = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Offer a config while idle: transfer edge, then apply edge.
    task automatic send_cfg(input logic [31:0] hi, input logic [31:0] lo);
        int waited = 0;
        cfg_if.cfg_high_time = hi;
        cfg_if.cfg_low_time  = lo;
        cfg_if.cfg_valid     = 1'b1;
        while (!cfg_if.cfg_ready && waited < 50) begin
            step();
            waited++;
        end
        n_checks++;
        if (waited >= 50) begin
            n_fail++;
            $display("FAIL send_cfg_ready_timeout: got ready=%b expected 1", cfg_if.cfg_ready);
        end
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (signal_out !== 1'b0) begin n_fail++; $display("FAIL reset_signal_out: got %b expected 0", signal_out); end
        n_checks++;
        if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
        n_checks++;
        if (cfg_applied !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_applied: got %b expected 0", cfg_applied); end
        n_checks++;
        if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_error: got %b expected 0", cfg_error); end
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_bring_up();
        logic [9:0] exp_o;
        logic [9:0] exp_p;
        exp_o = 10'b1110011100;
        exp_p = 10'b1000010000;
        do_reset();
        send_cfg(32'd3, 32'd2);
        n_checks++;
        if (cfg_applied !== 1'b1) begin n_fail++; $display("FAIL bringup_applied: got %b expected 1", cfg_applied); end
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bringup_ready: got %b expected 1", cfg_if.cfg_ready); end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (signal_out !== exp_o[9-i]) begin n_fail++; $display("FAIL bringup_out[%0d]: got %b expected %b", i, signal_out, exp_o[9-i]); end
            n_checks++;
            if (period_start !== exp_p[9-i]) begin n_fail++; $display("FAIL bringup_pstart[%0d]: got %b expected %b", i, period_start, exp_p[9-i]); end
        end
    endtask

    task automatic test_glitch_free_update();
        logic [7:0] exp_o;
        logic [7:0] exp_r;
        logic [7:0] exp_a;
        logic [7:0] exp_p;
        exp_o = 8'b11001010;
        exp_r = 8'b00001111;
        exp_a = 8'b00001000;
        exp_p = 8'b00001010;
        do_reset();
        send_cfg(32'd3, 32'd2);
        enable = 1'b1;
        step();
        cfg_if.cfg_high_time = 32'd1;
        cfg_if.cfg_low_time  = 32'd1;
        cfg_if.cfg_valid     = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n_checks++;
            if (signal_out !== exp_o[7-i]) begin n_fail++; $display("FAIL update_out[%0d]: got %b expected %b", i, signal_out, exp_o[7-i]); end
            n_checks++;
            if (cfg_if.cfg_ready !== exp_r[7-i]) begin n_fail++; $display("FAIL update_ready[%0d]: got %b expected %b", i, cfg_if.cfg_ready, exp_r[7-i]); end
            n_checks++;
            if (cfg_applied !== exp_a[7-i]) begin n_fail++; $display("FAIL update_applied[%0d]: got %b expected %b", i, cfg_applied, exp_a[7-i]); end
            n_checks++;
            if (period_start !== exp_p[7-i]) begin n_fail++; $display("FAIL update_pstart[%0d]: got %b expected %b", i, period_start, exp_p[7-i]); end
        end
    endtask

    task automatic test_degenerate();
        int ps_count;
        int hi_count;
        do_reset();
        send_cfg(32'd4, 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (signal_out !== 1'b1) begin n_fail++; $display("FAIL hi_only_out[%0d]: got %b expected 1", i, signal_out); end
            n_checks++;
            if (period_start !== ((i % 4) == 0)) begin n_fail++; $display("FAIL hi_only_pstart[%0d]: got %b expected %b", i, period_start, ((i % 4) == 0)); end
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (signal_out !== 1'b0) begin n_fail++; $display("FAIL hi_only_disable_out: got %b expected 0", signal_out); end
        send_cfg(32'd0, 32'd4);
        n_checks++;
        if (cfg_applied !== 1'b1) begin n_fail++; $display("FAIL lo_only_applied: got %b expected 1", cfg_applied); end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (signal_out !== 1'b0) begin n_fail++; $display("FAIL lo_only_out[%0d]: got %b expected 0", i, signal_out); end
            n_checks++;
            if (period_start !== ((i % 4) == 0)) begin n_fail++; $display("FAIL lo_only_pstart[%0d]: got %b expected %b", i, period_start, ((i % 4) == 0)); end
        end
        cfg_if.cfg_high_time = 32'd0;
        cfg_if.cfg_low_time  = 32'd0;
        cfg_if.cfg_valid     = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL zero_cfg_error: got %b expected 1", cfg_error); end
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL zero_cfg_ready: got %b expected 1", cfg_if.cfg_ready); end
        step();
        n_checks++;
        if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL zero_cfg_error_pulse: got %b expected 0", cfg_error); end
        ps_count = 0;
        hi_count = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (period_start) ps_count++;
            if (signal_out) hi_count++;
        end
        n_checks++;
        if (ps_count !== 2) begin n_fail++; $display("FAIL zero_cfg_kept_pstarts: got %0d expected 2", ps_count); end
        n_checks++;
        if (hi_count !== 0) begin n_fail++; $display("FAIL zero_cfg_kept_highs: got %0d expected 0", hi_count); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        send_cfg(32'd10, 32'd10);
        enable = 1'b1;
        step();
        n_checks++;
        if ((signal_out !== 1'b1) || (period_start !== 1'b1)) begin
            n_fail++;
            $display("FAIL drop_first_cycle: got out=%b ps=%b expected out=1 ps=1", signal_out, period_start);
        end
        repeat (4) step();
        enable = 1'b0;
        step();
        n_checks++;
        if (signal_out !== 1'b0) begin n_fail++; $display("FAIL drop_out: got %b expected 0", signal_out); end
        repeat (3) step();
        enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            n_checks++;
            if (signal_out !== (i < 10)) begin n_fail++; $display("FAIL reenable_out[%0d]: got %b expected %b", i, signal_out, (i < 10)); end
            if (i == 0) begin
                n_checks++;
                if (period_start !== 1'b1) begin n_fail++; $display("FAIL reenable_pstart: got %b expected 1", period_start); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_o;
        logic [6:0] exp_a;
        exp_o = 7'b0011101;
        exp_a = 7'b0010000;
        do_reset();
        send_cfg(32'd1, 32'd1);
        enable = 1'b1;
        step();
        cfg_if.cfg_high_time = 32'd2;
        cfg_if.cfg_low_time  = 32'd2;
        cfg_if.cfg_valid     = 1'b1;
        step();
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", cfg_if.cfg_ready); end
        cfg_if.cfg_high_time = 32'd3;
        cfg_if.cfg_low_time  = 32'd1;
        step();
        n_checks++;
        if ((cfg_applied !== 1'b1) || (cfg_if.cfg_ready !== 1'b1) || (signal_out !== 1'b1) || (period_start !== 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_apply: got applied=%b ready=%b out=%b ps=%b expected 1 1 1 1",
                     cfg_applied, cfg_if.cfg_ready, signal_out, period_start);
        end
        step();
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got ready=%b expected 0", cfg_if.cfg_ready); end
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (signal_out !== exp_o[6-i]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %b expected %b", i, signal_out, exp_o[6-i]); end
            n_checks++;
            if (cfg_applied !== exp_a[6-i]) begin n_fail++; $display("FAIL b2b_applied[%0d]: got %b expected %b", i, cfg_applied, exp_a[6-i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_cfg(32'd3, 32'd2);
        enable = 1'b1;
        step();
        cfg_if.cfg_high_time = 32'd5;
        cfg_if.cfg_low_time  = 32'd5;
        cfg_if.cfg_valid     = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        step();
        n_checks++;
        if ((signal_out !== 1'b0) || (cfg_if.cfg_ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL areset_pre: got out=%b ready=%b expected 0 0", signal_out, cfg_if.cfg_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", cfg_if.cfg_ready); end
        n_checks++;
        if ({signal_out, period_start, cfg_applied, cfg_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b expected 0000", {signal_out, period_start, cfg_applied, cfg_error});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if ((signal_out !== 1'b0) || (period_start !== 1'b0)) begin
                n_fail++;
                $display("FAIL areset_idle[%0d]: got out=%b ps=%b expected 0 0", i, signal_out, period_start);
            end
        end
    endtask

    initial begin
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_high_time = '0;
        cfg_if.cfg_low_time  = '0;
        test_reset();
        test_bring_up();
        test_glitch_free_update();
        test_degenerate();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
